pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
// Owns the program counter for core0. Consumes the jump/branch decision from flow_control
// and the call/return and interrupt controls, and sequences the next fetch address.
// Keeps a hardware call stack of return addresses and inserts a one-cycle squash bubble
// after every redirect. Sits between decode/flow_control and the instruction fetch port.
// PARAMETERS
// PROGRAM_ADDR_WIDTH  16      width of pc, target and stack entries
// CALL_STACK_DEPTH    16      number of return-address entries (power of 2, >=2)
// RESET_PC            0       pc value loaded on reset
// INTERRUPT_VECTOR    'h0010  pc loaded on interrupt entry
// PORTS
// clk              in   1      rising-edge clock
// reset_n          in   1      asynchronous, active-low reset
// stall            in   1      hold: no pc update, no stack op, no interrupt entry
// jump             in   1      from flow_control: unconditional redirect to target
// branch           in   1      from flow_control: taken branch to target
// call             in   1      current instr is a call (qualifies jump; pushes return)
// ret              in   1      current instr is a return (pops pc from stack)
// target           in   PAW    redirect address for jump/branch
// interrupt_req    in   1      level interrupt request
// interrupt_ack    out  1      one-cycle pulse acknowledging interrupt entry
// pc               out  PAW    current fetch address
// fetch_valid      out  1      pc is a valid fetch this cycle (0 = squash bubble)
// call_depth       out  $clog2(CALL_STACK_DEPTH)+1  number of valid stack entries
// stack_overflow   out  1      sticky: push attempted while full
// stack_underflow  out  1      sticky: pop attempted while empty
// BEHAVIOUR
// - Reset (reset_n=0, async): pc=RESET_PC, state=FLUSH, fetch_valid=0, interrupt_ack=0,
//   call_depth=0, both sticky flags=0, in_isr=0. Reset mid-operation discards the stack.
// - States: RUN (fetch_valid=1), FLUSH (fetch_valid=0). FLUSH always lasts exactly 1 cycle
//   (ignores stall and all controls), then RUN. fetch_valid is decoded from state.
// - RUN, stall=1: all registers hold; interrupt_ack=0.
// - RUN, stall=0: next-pc priority, evaluated on this cycle's inputs:
//   1. ret: if depth>0, pc<=stack[top], depth-1, ->FLUSH. If depth==0, set
//      stack_underflow, pc<=pc+1, stay RUN.
//   2. jump|branch: pc<=target, ->FLUSH. If call also set: push pc+1. If depth==
//      CALL_STACK_DEPTH, drop the push, set stack_overflow, and redirect anyway.
//   3. interrupt_req && !in_isr (only when ret, jump, branch and call are all 0):
//      push pc+1 (same overflow rule), pc<=INTERRUPT_VECTOR, isr_base<=depth
//      before push, in_isr<=1, ->FLUSH.
//   4. otherwise pc<=pc+1 (call without jump|branch is ignored).
// - interrupt_ack: registered, high for exactly the single FLUSH cycle following entry.
// - in_isr clears on a successful ret whose pre-pop depth == isr_base+1. Nested calls inside
//   the ISR do not clear it. Interrupts are not re-entered while in_isr=1.
// - pc+1 and all stack entries wrap modulo 2^PROGRAM_ADDR_WIDTH.
// - Stack is LIFO. Push and pop never occur in the same cycle. Sticky flags clear only on reset.
// TESTING
// - Reset release, no controls: fetch_valid 0 for 1 cycle, then pc 0,1,2,3 with fetch_valid=1.
// - pc=5, jump=1, call=1, target='h40 -> next pc='h40, bubble, call_depth=1. A later ret
//   -> pc=6, bubble, call_depth=0.
// - Fill 16 calls, then a 17th call -> stack_overflow=1, depth stays 16, pc=target.
//   Then 16 rets unwind in LIFO order.
// - ret at depth 0 -> stack_underflow=1, pc increments, no bubble.
// - pc=9, interrupt_req held high -> pc='h10, interrupt_ack pulses once. A nested call/ret
//   keeps in_isr=1. Final ret -> pc='hA. Req still high -> re-entered after one RUN cycle.
// - stall=1 with jump and interrupt_req -> pc, depth and state hold. Also pc='hFFFF -> 'h0000.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter sequencer for core0: next-fetch selection, hardware call stack,
// interrupt entry, and a one-cycle squash bubble after every redirect.
module pc_sequencer #(
  parameter int PROGRAM_ADDR_WIDTH = 16,
  parameter int CALL_STACK_DEPTH   = 16,
  parameter logic [PROGRAM_ADDR_WIDTH-1:0] RESET_PC         = '0,
  parameter logic [PROGRAM_ADDR_WIDTH-1:0] INTERRUPT_VECTOR = 'h0010
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  stall,
  input  logic                                  jump,
  input  logic                                  branch,
  input  logic                                  call,
  input  logic                                  ret,
  input  logic [PROGRAM_ADDR_WIDTH-1:0]         target,
  input  logic                                  interrupt_req,
  output logic                                  interrupt_ack,
  output logic [PROGRAM_ADDR_WIDTH-1:0]         pc,
  output logic                                  fetch_valid,
  output logic [$clog2(CALL_STACK_DEPTH):0]     call_depth,
  output logic                                  stack_overflow,
  output logic                                  stack_underflow,
  output logic                                  dbg_state,
  output logic                                  dbg_in_isr
);

  localparam int PAW = PROGRAM_ADDR_WIDTH;
  localparam int SPW = $clog2(CALL_STACK_DEPTH);
  localparam int DW  = SPW + 1;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [PAW-1:0] pc_q, pc_d;
  logic [DW-1:0]  depth_q, depth_d;
  logic [DW-1:0]  isr_base_q, isr_base_d;
  logic           in_isr_q, in_isr_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic           ack_q, ack_d;
  logic [PAW-1:0] stack_q [CALL_STACK_DEPTH];

  logic [PAW-1:0] pc_inc;
  logic [SPW-1:0] top_idx;
  logic           full, empty, push;

  assign pc_inc  = pc_q + PAW'(1);
  // Low bits of depth minus one wrap correctly even when the stack is full.
  assign top_idx = depth_q[SPW-1:0] - SPW'(1);
  assign full    = (depth_q == DW'(CALL_STACK_DEPTH));
  assign empty   = (depth_q == '0);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    depth_d    = depth_q;
    isr_base_d = isr_base_q;
    in_isr_d   = in_isr_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    ack_d      = 1'b0;
    push       = 1'b0;
    case (state_q)
      FLUSH: state_d = RUN;
      RUN: begin
        if (!stall) begin
          if (ret) begin
            if (!empty) begin
              pc_d    = stack_q[top_idx];
              depth_d = depth_q - DW'(1);
              state_d = FLUSH;
              if (in_isr_q && (depth_q == (isr_base_q + DW'(1)))) in_isr_d = 1'b0;
            end else begin
              unf_d = 1'b1;
              pc_d  = pc_inc;
            end
          end else if (jump || branch) begin
            pc_d    = target;
            state_d = FLUSH;
            if (call) begin
              if (full) begin
                ovf_d = 1'b1;
              end else begin
                push    = 1'b1;
                depth_d = depth_q + DW'(1);
              end
            end
          end else if (interrupt_req && !in_isr_q && !call) begin
            // Entry still vectors when the return push is dropped on overflow.
            if (full) begin
              ovf_d = 1'b1;
            end else begin
              push    = 1'b1;
              depth_d = depth_q + DW'(1);
            end
            pc_d       = INTERRUPT_VECTOR;
            isr_base_d = depth_q;
            in_isr_d   = 1'b1;
            ack_d      = 1'b1;
            state_d    = FLUSH;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FLUSH;
      pc_q       <= RESET_PC;
      depth_q    <= '0;
      isr_base_q <= '0;
      in_isr_q   <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      depth_q    <= depth_d;
      isr_base_q <= isr_base_d;
      in_isr_q   <= in_isr_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      ack_q      <= ack_d;
    end
  end

  // Entries above depth are don't-care, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push) stack_q[depth_q[SPW-1:0]] <= pc_inc;
  end

  assign pc              = pc_q;
  assign fetch_valid     = (state_q == RUN);
  assign interrupt_ack   = ack_q;
  assign call_depth      = depth_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;
  assign dbg_state       = state_q;
  assign dbg_in_isr      = in_isr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, call/ret, stack limits, interrupts, stall, wrap.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall, jump, branch, call, ret, interrupt_req;
  logic [15:0] target;
  logic        interrupt_ack, fetch_valid, stack_overflow, stack_underflow;
  logic        dbg_state, dbg_in_isr;
  logic [15:0] pc;
  logic [4:0]  call_depth;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  pc_sequencer dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .jump(jump), .branch(branch),
    .call(call), .ret(ret), .target(target), .interrupt_req(interrupt_req),
    .interrupt_ack(interrupt_ack), .pc(pc), .fetch_valid(fetch_valid),
    .call_depth(call_depth), .stack_overflow(stack_overflow),
    .stack_underflow(stack_underflow), .dbg_state(dbg_state), .dbg_in_isr(dbg_in_isr)
  );

  always #5 clk = ~clk;

  task automatic clear_ctl();
    stall = 0; jump = 0; branch = 0; call = 0; ret = 0; interrupt_req = 0; target = '0;
  endtask

  // Leaves the bench at the first RUN-cycle negedge with pc = 0.
  task automatic do_reset();
    clear_ctl();
    exp_q.delete();
    @(negedge clk); reset_n = 0;
    @(negedge clk); reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_ctl();
    reset_n = 0;
    @(negedge clk);
    n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h want 0000", pc); end
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv: got %b want 0", fetch_valid); end
    n_checks++; if (interrupt_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", interrupt_ack); end
    n_checks++; if (call_depth !== 5'd0) begin n_fail++; $display("FAIL reset_depth: got %0d want 0", call_depth); end
    n_checks++; if ({stack_overflow, stack_underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {stack_overflow, stack_underflow}); end
    reset_n = 1;
    #1;
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL release_bubble: got %b want 0", fetch_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (pc !== 16'(i)) begin n_fail++; $display("FAIL release_pc%0d: got %h want %h", i, pc, 16'(i)); end
      n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL release_fv%0d: got %b want 1", i, fetch_valid); end
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    repeat (5) @(negedge clk);
    jump = 1; call = 1; target = 16'h0040;
    @(negedge clk);
    n_checks++; if (pc !== 16'h0040) begin n_fail++; $display("FAIL call_pc: got %h want 0040", pc); end
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL call_bubble: got %b want 0", fetch_valid); end
    n_checks++; if (call_depth !== 5'd1) begin n_fail++; $display("FAIL call_depth: got %0d want 1", call_depth); end
    clear_ctl();
    @(negedge clk);
    n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL call_run: got %b want 1", fetch_valid); end
    repeat (2) @(negedge clk);
    ret = 1;
    @(negedge clk);
    n_checks++; if (pc !== 16'h0006) begin n_fail++; $display("FAIL ret_pc: got %h want 0006", pc); end
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL ret_bubble: got %b want 0", fetch_valid); end
    n_checks++; if (call_depth !== 5'd0) begin n_fail++; $display("FAIL ret_depth: got %0d want 0", call_depth); end
    clear_ctl();
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (pc !== 16'h0007) begin n_fail++; $display("FAIL ret_next: got %h want 0007", pc); end
    // Asynchronous reset in mid-cycle after a push discards the stack at once.
    jump = 1; call = 1; target = 16'h0080;
    @(negedge clk);
    clear_ctl();
    #2 reset_n = 0;
    #1;
    n_checks++; if (call_depth !== 5'd0) begin n_fail++; $display("FAIL async_depth: got %0d want 0", call_depth); end
    n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL async_pc: got %h want 0000", pc); end
    @(negedge clk); reset_n = 1;
  endtask

  task automatic test_overflow_unwind();
    logic [15:0] cur;
    logic [15:0] e;
    do_reset();
    cur = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(cur + 16'h0001);
      jump = 1; call = 1; target = 16'h0100 + 16'(i * 16);
      @(negedge clk);
      n_checks++; if (call_depth !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_depth%0d: got %0d want %0d", i, call_depth, i + 1); end
      cur = target;
      clear_ctl();
      @(negedge clk);
    end
    jump = 1; call = 1; target = 16'h0300;
    @(negedge clk);
    n_checks++; if (stack_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", stack_overflow); end
    n_checks++; if (call_depth !== 5'd16) begin n_fail++; $display("FAIL ovf_depth: got %0d want 16", call_depth); end
    n_checks++; if (pc !== 16'h0300) begin n_fail++; $display("FAIL ovf_pc: got %h want 0300", pc); end
    clear_ctl();
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      ret = 1;
      @(negedge clk);
      e = exp_q.pop_back();
      n_checks++; if (pc !== e) begin n_fail++; $display("FAIL unwind_pc%0d: got %h want %h", i, pc, e); end
      n_checks++; if (call_depth !== 5'(15 - i)) begin n_fail++; $display("FAIL unwind_depth%0d: got %0d want %0d", i, call_depth, 15 - i); end
      clear_ctl();
      @(negedge clk);
    end
    n_checks++; if (stack_underflow !== 1'b0) begin n_fail++; $display("FAIL unwind_unf: got %b want 0", stack_underflow); end
  endtask

  // Runs straight after the unwind: depth 0, pc = 1, in RUN.
  task automatic test_underflow();
    ret = 1;
    @(negedge clk);
    n_checks++; if (pc !== 16'h0002) begin n_fail++; $display("FAIL unf_pc: got %h want 0002", pc); end
    n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL unf_nobubble: got %b want 1", fetch_valid); end
    n_checks++; if (stack_underflow !== 1'b1) begin n_fail++; $display("FAIL unf_flag: got %b want 1", stack_underflow); end
    n_checks++; if (call_depth !== 5'd0) begin n_fail++; $display("FAIL unf_depth: got %0d want 0", call_depth); end
    clear_ctl();
    @(negedge clk);
    n_checks++; if ({stack_overflow, stack_underflow} !== 2'b11) begin n_fail++; $display("FAIL sticky_flags: got %b want 11", {stack_overflow, stack_underflow}); end
    n_checks++; if (pc !== 16'h0003) begin n_fail++; $display("FAIL unf_next: got %h want 0003", pc); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    jump = 1; target = 16'h0030;
    @(negedge clk);
    n_checks++; if (pc !== 16'h0030) begin n_fail++; $display("FAIL b2b_pc1: got %h want 0030", pc); end
    jump = 0; branch = 1; target = 16'h0060;
    @(negedge clk);
    n_checks++; if (pc !== 16'h0030 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_flush_ignores: got %h/%b want 0030/1", pc, fetch_valid); end
    @(negedge clk);
    n_checks++; if (pc !== 16'h0060 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_branch: got %h/%b want 0060/0", pc, fetch_valid); end
    clear_ctl();
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (pc !== 16'h0061) begin n_fail++; $display("FAIL b2b_next: got %h want 0061", pc); end
  endtask

  task automatic test_interrupt();
    do_reset();
    repeat (9) @(negedge clk);
    interrupt_req = 1;
    @(negedge clk);
    n_checks++; if (pc !== 16'h0010) begin n_fail++; $display("FAIL irq_pc: got %h want 0010", pc); end
    n_checks++; if (interrupt_ack !== 1'b1) begin n_fail++; $display("FAIL irq_ack: got %b want 1", interrupt_ack); end
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL irq_bubble: got %b want 0", fetch_valid); end
    n_checks++; if (call_depth !== 5'd1) begin n_fail++; $display("FAIL irq_depth: got %0d want 1", call_depth); end
    @(negedge clk);
    n_checks++; if (interrupt_ack !== 1'b0) begin n_fail++; $display("FAIL irq_ack_pulse: got %b want 0", interrupt_ack); end
    @(negedge clk);
    n_checks++; if (pc !== 16'h0011) begin n_fail++; $display("FAIL irq_no_reenter: got %h want 0011", pc); end
    jump = 1; call = 1; target = 16'h0020;
    @(negedge clk);
    n_checks++; if (call_depth !== 5'd2) begin n_fail++; $display("FAIL nest_depth: got %0d want 2", call_depth); end
    jump = 0; call = 0;
    @(negedge clk);
    ret = 1;
    @(negedge clk);
    n_checks++; if (pc !== 16'h0012) begin n_fail++; $display("FAIL nest_ret: got %h want 0012", pc); end
    ret = 0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (pc !== 16'h0013 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL nest_keeps_isr: got %h/%b want 0013/1", pc, fetch_valid); end
    ret = 1;
    @(negedge clk);
    n_checks++; if (pc !== 16'h000A) begin n_fail++; $display("FAIL isr_ret_pc: got %h want 000a", pc); end
    n_checks++; if (call_depth !== 5'd0) begin n_fail++; $display("FAIL isr_ret_depth: got %0d want 0", call_depth); end
    ret = 0;
    @(negedge clk);
    n_checks++; if (pc !== 16'h000A || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL isr_run_gap: got %h/%b want 000a/1", pc, fetch_valid); end
    @(negedge clk);
    n_checks++; if (pc !== 16'h0010 || interrupt_ack !== 1'b1) begin n_fail++; $display("FAIL irq_reenter: got %h/%b want 0010/1", pc, interrupt_ack); end
    clear_ctl();
    @(negedge clk);
  endtask

  task automatic test_stall();
    do_reset();
    repeat (3) @(negedge clk);
    stall = 1; jump = 1; call = 1; target = 16'h0077; interrupt_req = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (pc !== 16'h0003 || call_depth !== 5'd0) begin n_fail++; $display("FAIL stall_hold%0d: got %h/%0d want 0003/0", i, pc, call_depth); end
      n_checks++; if (fetch_valid !== 1'b1 || interrupt_ack !== 1'b0) begin n_fail++; $display("FAIL stall_state%0d: got %b/%b want 1/0", i, fetch_valid, interrupt_ack); end
    end
    clear_ctl();
    @(negedge clk);
    n_checks++; if (pc !== 16'h0004) begin n_fail++; $display("FAIL stall_release: got %h want 0004", pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    jump = 1; target = 16'hFFFF;
    @(negedge clk);
    clear_ctl();
    @(negedge clk);
    n_checks++; if (pc !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_start: got %h want ffff", pc); end
    @(negedge clk);
    n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc: got %h want 0000", pc); end
    jump = 1; target = 16'hFFFF;
    @(negedge clk);
    clear_ctl();
    @(negedge clk);
    jump = 1; call = 1; target = 16'h0050;
    @(negedge clk);
    clear_ctl();
    @(negedge clk);
    ret = 1;
    @(negedge clk);
    n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL wrap_ret: got %h want 0000", pc); end
    clear_ctl();
    @(negedge clk);
  endtask

  initial begin
    clear_ctl();
    test_reset();
    test_call_ret();
    test_overflow_unwind();
    test_underflow();
    test_back_to_back();
    test_interrupt();
    test_stall();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
